// File: rtl/draw_pkg.sv
// Shared definitions for the draw-port arbiter.
//   - requester index constants (background, bird, wall)
//   - arbiter state encoding
//   - default coordinate/colour widths and watchdog limit
package draw_pkg;

  localparam int N_REQ = 3;

  localparam logic [1:0] REQ_BG   = 2'd0;
  localparam logic [1:0] REQ_BIRD = 2'd1;
  localparam logic [1:0] REQ_WALL = 2'd2;

  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_C_W      = 3;
  localparam int DEF_MAX_HOLD = 20000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Ports:
//   eligible_i  requesters that may be granted now
//   rr_i        index of the most recent owner (search starts after it)
//   owner_o     chosen requester index (valid only when valid_o)
//   valid_o     at least one requester is eligible
module rr_pick3
  import draw_pkg::*;
(
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [1:0]       rr_i,
  output logic [1:0]       owner_o,
  output logic             valid_o
);

  logic [1:0] cand;

  // Search rr+1, rr+2, rr+3 (mod 3); the first eligible index wins.
  always_comb begin
    owner_o = REQ_BG;
    valid_o = 1'b0;
    cand    = REQ_BG;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(rr_i) + k) % 3);
      if (!valid_o && eligible_i[cand]) begin
        valid_o = 1'b1;
        owner_o = cand;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Shares the single VGA plot port between the background, bird and wall
// draw datapaths. Each requester is granted at most once per frame in
// round-robin order; a watchdog forces release of a stuck owner.
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   frame_tick               start-of-frame pulse, clears the served mask
//   req/pix_valid/done       per-requester request, pixel valid, last pixel
//   x_in/y_in/colour_in      packed per-requester pixel data (slot i = req i)
//   gnt                      one-hot grant (or zero)
//   plot, vga_x/y/colour     registered write port to vga_adapter
//   busy                     state is GRANT or RELEASE
//   frame_done               pulse when all three have been served
//   timeout_err              sticky watchdog flag
//   dbg_state_o/dbg_served_o internal state and served mask, for observation
//
// Handshake: a requester holds req until it sees its gnt bit. While granted
// it drives one pixel per cycle with pix_valid; done qualified by pix_valid
// marks the last pixel, which is still plotted. The grant then drops for one
// RELEASE cycle before the next owner is chosen.
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int C_W      = DEF_C_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   pix_valid,
  input  logic [N_REQ-1:0]   done,
  input  logic [3*X_W-1:0]   x_in,
  input  logic [3*Y_W-1:0]   y_in,
  input  logic [3*C_W-1:0]   colour_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               plot,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [C_W-1:0]     vga_colour,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err,
  output state_e             dbg_state_o,
  output logic [N_REQ-1:0]   dbg_served_o
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_e             state_q;
  logic [N_REQ-1:0]   gnt_q, served_q, served_d;
  logic [1:0]         rr_q, owner_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               plot_q, frame_done_q, frame_done_d, timeout_err_q;
  logic [X_W-1:0]     vga_x_q;
  logic [Y_W-1:0]     vga_y_q;
  logic [C_W-1:0]     vga_colour_q;

  logic [N_REQ-1:0]   eligible, set_mask;
  logic [1:0]         pick_owner;
  logic               pick_valid;
  logic               own_valid, own_done, release_now, force_now;
  logic [X_W-1:0]     own_x;
  logic [Y_W-1:0]     own_y;
  logic [C_W-1:0]     own_c;

  assign eligible = req & ~served_q;

  rr_pick3 u_pick (
    .eligible_i (eligible),
    .rr_i       (rr_q),
    .owner_o    (pick_owner),
    .valid_o    (pick_valid)
  );

  // Only the current owner's lanes are looked at; others are ignored.
  assign own_valid = pix_valid[owner_q];
  assign own_done  = done[owner_q];
  assign own_x     = x_in[owner_q*X_W +: X_W];
  assign own_y     = y_in[owner_q*Y_W +: Y_W];
  assign own_c     = colour_in[owner_q*C_W +: C_W];

  // A normal finish takes priority over the watchdog on the same cycle.
  always_comb begin
    release_now = 1'b0;
    force_now   = 1'b0;
    set_mask    = '0;
    if (state_q == GRANT) begin
      if (own_valid && own_done) begin
        release_now = 1'b1;
      end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
        release_now = 1'b1;
        force_now   = 1'b1;
      end
      if (release_now) set_mask = 3'b001 << owner_q;
    end
  end

  // frame_done reflects completion even when frame_tick clears the mask
  // on the same edge.
  assign frame_done_d = ((served_q | set_mask) == 3'b111) && (served_q != 3'b111);
  assign served_d     = frame_tick ? 3'b000 : (served_q | set_mask);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      plot_q        <= 1'b0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      served_q      <= '0;
      rr_q          <= REQ_WALL;
      owner_q       <= REQ_BG;
      hold_q        <= '0;
    end else begin
      served_q     <= served_d;
      frame_done_q <= frame_done_d;
      if (force_now) timeout_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          plot_q <= 1'b0;
          if (pick_valid) begin
            state_q <= GRANT;
            gnt_q   <= 3'b001 << pick_owner;
            owner_q <= pick_owner;
            rr_q    <= pick_owner;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          plot_q       <= own_valid && !force_now;
          vga_x_q      <= own_x;
          vga_y_q      <= own_y;
          vga_colour_q <= own_c;
          if (release_now) begin
            state_q <= RELEASE;
            gnt_q   <= '0;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        RELEASE: begin
          plot_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          plot_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign plot         = plot_q;
  assign vga_x        = vga_x_q;
  assign vga_y        = vga_y_q;
  assign vga_colour   = vga_colour_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = frame_done_q;
  assign timeout_err  = timeout_err_q;
  assign dbg_state_o  = state_q;
  assign dbg_served_o = served_q;

endmodule

// File: tb/tb_draw_arbiter.sv
module tb_draw_arbiter;
  import draw_pkg::*;

  localparam int X_W = 8, Y_W = 7, C_W = 3, MAX_HOLD = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn = 1'b0, frame_tick = 1'b0;
  logic [2:0]       req = '0, pix_valid = '0, done = '0;
  logic [3*X_W-1:0] x_in = '0;
  logic [3*Y_W-1:0] y_in = '0;
  logic [3*C_W-1:0] colour_in = '0;
  logic [2:0]       gnt, dbg_served;
  logic             plot, busy, frame_done, timeout_err;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [C_W-1:0]   vga_colour;
  state_e           dbg_state;

  draw_arbiter #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .req(req),
    .pix_valid(pix_valid), .done(done), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .gnt(gnt), .plot(plot), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err),
    .dbg_state_o(dbg_state), .dbg_served_o(dbg_served)
  );

  int n_pass = 0, n_total = 0;
  int plot_cnt = 0, fd_cnt = 0;
  bit x99_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 owner granted, 2 one-cycle gap after a release.
  int       m_phase, m_owner, m_rr, m_hold;
  bit [2:0] m_served, m_gnt;
  bit       m_plot, m_fd, m_to;
  bit [X_W-1:0] m_x;
  bit [Y_W-1:0] m_y;
  bit [C_W-1:0] m_c;

  task automatic model_step();
    bit [2:0] elig, ns;
    bit rel, frc, found;
    int pick;
    if (!resetn) begin
      m_phase = 0; m_owner = 0; m_rr = 2; m_hold = 0; m_served = '0;
      m_gnt = '0; m_plot = 0; m_fd = 0; m_to = 0; m_x = '0; m_y = '0; m_c = '0;
      return;
    end
    elig = req & ~m_served;
    rel = 0; frc = 0;
    if (m_phase == 1) begin
      if (pix_valid[m_owner] && done[m_owner]) rel = 1;
      else if (m_hold == MAX_HOLD - 1) begin rel = 1; frc = 1; end
    end
    ns = m_served;
    if (rel) ns[m_owner] = 1'b1;
    m_fd = (ns == 3'b111) && (m_served != 3'b111);
    m_served = frame_tick ? 3'b000 : ns;
    if (frc) m_to = 1;
    if (m_phase == 0) begin
      m_plot = 0;
      found = 0; pick = 0;
      for (int k = 1; k <= 3; k++)
        if (!found && elig[(m_rr + k) % 3]) begin found = 1; pick = (m_rr + k) % 3; end
      if (found) begin
        m_phase = 1; m_owner = pick; m_rr = pick; m_hold = 0; m_gnt = 3'b001 << pick;
      end
    end else if (m_phase == 1) begin
      m_plot = pix_valid[m_owner] && !frc;
      m_x = x_in[m_owner*X_W +: X_W];
      m_y = y_in[m_owner*Y_W +: Y_W];
      m_c = colour_in[m_owner*C_W +: C_W];
      if (rel) begin m_phase = 2; m_gnt = '0; end
      else m_hold++;
    end else begin
      m_plot = 0; m_phase = 0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    model_step();
    #1;
    check("gnt", gnt, m_gnt);
    check("plot", plot, m_plot);
    check("vga_x", vga_x, m_x);
    check("vga_y", vga_y, m_y);
    check("vga_colour", vga_colour, m_c);
    check("busy", busy, m_phase != 0);
    check("frame_done", frame_done, m_fd);
    check("timeout_err", timeout_err, m_to);
    check("served", dbg_served, m_served);
    if (plot) plot_cnt++;
    if (frame_done) fd_cnt++;
    if (plot && vga_x == 8'd99) x99_seen = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(input logic [2:0] want, input string name);
    for (int t = 0; t < 100 && gnt !== want; t++) @(negedge clk);
    check(name, gnt, want);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Sends npix pixels from requester i once granted; done on the last.
  task automatic serve(input int i, input int npix, input bit tick_on_last);
    logic [2:0] want;
    want = 3'b001 << i;
    wait_gnt(want, "gnt_owner");
    for (int k = 0; k < npix; k++) begin
      x_in[i*X_W +: X_W]      = 8'(16*i + k + 1);
      y_in[i*Y_W +: Y_W]      = 7'(10*i + k);
      colour_in[i*C_W +: C_W] = 3'(i + k);
      pix_valid = want;
      done      = (k == npix - 1) ? want : 3'b000;
      if (tick_on_last && k == npix - 1) frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      check("px_plot", plot, 1);
      check("px_x", vga_x, 16*i + k + 1);
    end
    pix_valid = '0;
    done      = '0;
    check("gnt_dropped", gnt, 0);
  endtask

  // ---------------- directed sequence ----------------
  int cnt;
  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_plot", plot, 0);
    check("rst_to", timeout_err, 0);
    resetn = 1'b1;

    // Full frame: 0 -> 1 -> 2, four pixels each.
    plot_cnt = 0; fd_cnt = 0;
    req = 3'b111;
    pulse_tick();
    for (int i = 0; i < 3; i++) serve(i, 4, 1'b0);
    repeat (3) @(negedge clk);
    check("frame_plots", plot_cnt, 12);
    check("frame_done_cnt", fd_cnt, 1);

    // No grants after frame_done until the next frame_tick.
    req = 3'b010;
    cnt = 0;
    repeat (50) begin @(negedge clk); if (gnt != 3'b000) cnt++; end
    check("no_gnt_after_frame", cnt, 0);
    pulse_tick();
    @(negedge clk);
    check("gnt_after_tick", gnt, 3'b010);

    // Requester 2 noise while requester 1 owns the port.
    for (int k = 0; k < 4; k++) begin
      x_in      = {8'd99, 8'(20 + k), 8'd0};
      pix_valid = 3'b110;
      done      = {1'b1, (k == 3), 1'b0};
      @(negedge clk);
      check("noise_plot", plot, 1);
      check("noise_x", vga_x, 20 + k);
    end
    pix_valid = '0; done = '0; x_in = '0;
    repeat (2) @(negedge clk);
    check("no_x99", x99_seen, 0);

    // Watchdog on requester 0, which never sends done.
    req = 3'b011;
    pulse_tick();
    wait_gnt(3'b001, "wd_gnt0");
    x_in[0 +: X_W] = 8'd55;
    pix_valid = 3'b001;
    cnt = 0;
    while (gnt[0] && cnt < 40) begin cnt++; @(negedge clk); end
    check("wd_hold_cycles", cnt, 16);
    check("wd_flag", timeout_err, 1);
    check("wd_plot_forced", plot, 0);
    pix_valid = '0;
    @(negedge clk);
    check("wd_idle_gap", gnt, 0);
    @(negedge clk);
    check("wd_next_owner", gnt, 3'b010);
    serve(1, 3, 1'b0);
    check("wd_sticky", timeout_err, 1);

    // done and frame_tick on the same edge: requester 0 is served again.
    req = 3'b001;
    pulse_tick();
    serve(0, 2, 1'b1);
    check("tick_wins_served", dbg_served, 3'b000);
    serve(0, 2, 1'b0);
    @(negedge clk);
    check("served_after_regrant", dbg_served, 3'b001);

    // Reset in the middle of a grant.
    req = 3'b010;
    pulse_tick();
    wait_gnt(3'b010, "pre_rst_gnt");
    pix_valid = 3'b010;
    req = 3'b111;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_gnt", gnt, 0);
    check("midrst_plot", plot, 0);
    check("midrst_to", timeout_err, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", gnt, 3'b001);
    check("post_rst_plot", plot, 0);
    pix_valid = '0;
    serve(0, 2, 1'b0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
